onehot_decoder_seq: RTL

Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with a valid/ready select interface and an optional self-running scan mode. The scan mode walks the active output across all lines with a programmable dwell time per line. It succeeds the fixed 2-to-4 combinational decoders and drives one-hot enables for LED/mux/row-select logic in the workshop designs.

---
 rtl/onehot_decoder_pkg.sv | 21 ++
 rtl/onehot_decoder_seq_if.sv | 30 +++
 rtl/onehot_decoder_seq_dwell_timer.sv | 29 ++
 rtl/onehot_decoder_seq.sv | 129 ++++++++++++
 4 files changed

// File: rtl/onehot_decoder_pkg.sv
// Shared types and helpers for the sequenced one-hot decoder.
// The scan mode is compiled in only when ONEHOT_DECODER_SCAN_EN is defined.
package onehot_decoder_pkg;

  localparam int MAX_SEL_W = 8;
  localparam int MAX_OUT_W = 1 << MAX_SEL_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

  // Callers narrow the result to their own output width with a size cast.
  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
    logic [MAX_OUT_W-1:0] one;
    one = 1;
    return one << idx;
  endfunction

endpackage

// File: rtl/onehot_decoder_seq_if.sv
// Select/scan handshake bundle between a controller (master) and the decoder (slave).
// Widths must match the SEL_W/DWELL_W of the decoder instance it connects to.
interface onehot_decoder_seq_if #(
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 4
);
  localparam int OUT_W = 2 ** SEL_W;

  logic               en;
  logic [SEL_W-1:0]   sel;
  logic               sel_valid;
  logic               sel_ready;
  logic               scan_start;
  logic               scan_stop;
  logic [DWELL_W-1:0] dwell;
  logic [OUT_W-1:0]   y;
  logic               y_valid;
  logic               scan_busy;
  logic               scan_wrap;

  modport master (
    output en, sel, sel_valid, scan_start, scan_stop, dwell,
    input  sel_ready, y, y_valid, scan_busy, scan_wrap
  );

  modport slave (
    input  en, sel, sel_valid, scan_start, scan_stop, dwell,
    output sel_ready, y, y_valid, scan_busy, scan_wrap
  );
endinterface

// File: rtl/onehot_decoder_seq_dwell_timer.sv
// Down-counting dwell timer: expire fires on the last cycle of a dwell period.
// Used only when ONEHOT_DECODER_SCAN_EN is defined.
module dwell_timer #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  input  logic               run,
  output logic               expire
);

  logic [DWELL_W-1:0] cnt;

  assign expire = run && (cnt == '0);

  // Load wins over counting so a reload on expiry starts the next period cleanly.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (run && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/onehot_decoder_seq.sv
// Registered SEL_W-to-2**SEL_W one-hot decoder with valid/ready select and
// an optional auto-scan mode enabled by the ONEHOT_DECODER_SCAN_EN macro.
module onehot_decoder_seq
  import onehot_decoder_pkg::*;
#(
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 4
) (
  input logic                 clk,
  input logic                 rst,
  onehot_decoder_seq_if.slave bus
);

  localparam int OUT_W = 2 ** SEL_W;

  state_t           state;
  logic [OUT_W-1:0] y_q;
  logic             y_valid_q;
  logic             accept;

  function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] i);
    return OUT_W'(onehot(MAX_SEL_W'(i)));
  endfunction

  assign accept      = bus.sel_valid && bus.sel_ready;
  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;

`ifdef ONEHOT_DECODER_SCAN_EN

  logic [SEL_W-1:0]   idx;
  logic [DWELL_W-1:0] dwell_q;
  logic               scan_busy_q;
  logic               scan_wrap_q;
  logic               in_scan;
  logic               start_go;
  logic               expire;

  assign in_scan       = (state == SCAN);
  assign start_go      = bus.en && !in_scan && bus.scan_start && !bus.scan_stop;
  assign bus.sel_ready = bus.en && !in_scan && !bus.scan_start;
  assign bus.scan_busy = scan_busy_q;
  assign bus.scan_wrap = scan_wrap_q;

  // The first period uses the live dwell input; later periods reuse the latched copy.
  dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (start_go || expire),
    .load_val (in_scan ? dwell_q : bus.dwell),
    .run      (in_scan),
    .expire   (expire)
  );

  always_ff @(posedge clk) begin
    if (rst || !bus.en) begin
      state       <= IDLE;
      y_q         <= '0;
      y_valid_q   <= 1'b0;
      scan_busy_q <= 1'b0;
      scan_wrap_q <= 1'b0;
      idx         <= '0;
      if (rst) begin
        dwell_q <= '0;
      end
    end else begin
      case (state)
        SCAN: begin
          if (bus.scan_stop) begin
            state       <= IDLE;
            y_q         <= '0;
            y_valid_q   <= 1'b0;
            scan_busy_q <= 1'b0;
            scan_wrap_q <= 1'b0;
            idx         <= '0;
          end else if (expire) begin
            idx         <= idx + 1'b1;
            y_q         <= decode(idx + 1'b1);
            scan_wrap_q <= &idx;
          end else begin
            scan_wrap_q <= 1'b0;
          end
        end
        default: begin
          // A simultaneous stop cancels the start; sel_ready already blocks the accept.
          if (start_go) begin
            state       <= SCAN;
            idx         <= '0;
            y_q         <= decode('0);
            y_valid_q   <= 1'b1;
            scan_busy_q <= 1'b1;
            scan_wrap_q <= 1'b0;
            dwell_q     <= bus.dwell;
          end else if (accept) begin
            state     <= HOLD;
            y_q       <= decode(bus.sel);
            y_valid_q <= 1'b1;
          end
        end
      endcase
    end
  end

`else

  logic unused_scan_inputs;

  assign unused_scan_inputs = ^{bus.scan_start, bus.scan_stop, bus.dwell};
  assign bus.sel_ready      = bus.en;
  assign bus.scan_busy      = 1'b0;
  assign bus.scan_wrap      = 1'b0;

  always_ff @(posedge clk) begin
    if (rst || !bus.en) begin
      state     <= IDLE;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else if (accept) begin
      state     <= HOLD;
      y_q       <= decode(bus.sel);
      y_valid_q <= 1'b1;
    end
  end

`endif

endmodule
